// File: rtl/aes_chain_sequencer.sv
// Multi-block ECB / CBC-enc / CBC-dec / CTR chaining controller around a single-block AES core.
// Optional core watchdog in S_RUN: define AES_SEQ_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module aes_chain_sequencer #(
  parameter int NBLK_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_start,
  input  logic [2:0]        cfg_mode,
  input  logic [127:0]      cfg_iv,
  input  logic [NBLK_W-1:0] cfg_nblocks,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NBLK_W-1:0] blocks_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              core_start,
  output logic              core_decrypt,
  output logic [127:0]      core_in,
  input  logic              core_done,
  input  logic [127:0]      core_result
);

`ifdef AES_SEQ_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] M_ECB  = 3'd0;
  localparam logic [2:0] M_CBCE = 3'd1;
  localparam logic [2:0] M_CBCD = 3'd2;
  localparam logic [2:0] M_CTR  = 3'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_OUT} state_e;

  state_e            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [NBLK_W-1:0] nblk_q, nblk_d;
  logic [NBLK_W-1:0] bdone_q, bdone_d;
  logic [127:0]      chain_q, chain_d;
  logic [127:0]      blk_q, blk_d;
  logic [127:0]      core_in_q, core_in_d;
  logic [127:0]      out_q, out_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [31:0]       wd_q, wd_d;
  logic              wd_expire;
  logic [NBLK_W-1:0] bdone_inc;

  assign wd_expire = WD_EN && (wd_q == WD_LAST);
  assign bdone_inc = bdone_q + NBLK_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      mode_q    <= M_ECB;
      nblk_q    <= '0;
      bdone_q   <= '0;
      chain_q   <= '0;
      blk_q     <= '0;
      core_in_q <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      nblk_q    <= nblk_d;
      bdone_q   <= bdone_d;
      chain_q   <= chain_d;
      blk_q     <= blk_d;
      core_in_q <= core_in_d;
      out_q     <= out_d;
      err_q     <= err_d;
      done_q    <= done_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nblk_d    = nblk_q;
    bdone_d   = bdone_q;
    chain_d   = chain_q;
    blk_d     = blk_q;
    core_in_d = core_in_q;
    out_d     = out_q;
    err_d     = err_q;
    done_d    = 1'b0;
    wd_d      = wd_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          mode_d  = cfg_mode;
          nblk_d  = cfg_nblocks;
          chain_d = cfg_iv;
          bdone_d = '0;
          err_d   = 1'b0;
          // Invalid modes (4-7) and empty jobs finish without leaving idle
          if (cfg_mode[2]) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (cfg_nblocks == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          blk_d = in_data;
          case (mode_q)
            M_CBCE:  core_in_d = in_data ^ chain_q;
            M_CTR:   core_in_d = chain_q;
            default: core_in_d = in_data;
          endcase
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (core_done) begin
          case (mode_q)
            M_CBCE: begin
              out_d   = core_result;
              chain_d = core_result;
            end
            M_CBCD: begin
              out_d   = core_result ^ chain_q;
              chain_d = blk_q;
            end
            M_CTR: begin
              out_d   = core_result ^ blk_q;
              chain_d = chain_q + 128'd1;
            end
            default: out_d = core_result;
          endcase
          state_d = S_OUT;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          bdone_d = bdone_inc;
          if (bdone_inc == nblk_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign blocks_done  = bdone_q;
  assign in_ready     = (state_q == S_LOAD);
  assign out_valid    = (state_q == S_OUT);
  assign out_data     = out_q;
  assign core_start   = (state_q == S_START);
  assign core_decrypt = (mode_q == M_CBCD);
  assign core_in      = core_in_q;

endmodule

// File: doc/aes_chain_sequencer.md
# aes_chain_sequencer

Multi-block chaining controller that sits between the register-level control path and the single-block AES core. It accepts a configured job (mode, IV, block count) and streams 128-bit blocks through valid/ready ports. For each block it drives one core start/done transaction, applying the ECB, CBC-encrypt, CBC-decrypt or CTR chaining arithmetic around the core. Software programs one job and moves data; the core is never started by software directly.

## Interface
- NBLK_W, 16: width of block count and progress counter.
- TIMEOUT_CYCLES, 1024: core watchdog limit, used only when `AES_SEQ_TIMEOUT_EN` is defined.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle job start; honoured only in S_IDLE.
- cfg_mode  in  3  0=ECB, 1=CBC-enc, 2=CBC-dec, 3=CTR, 4-7 invalid.
- cfg_iv  in  128  IV (CBC) or initial counter (CTR).
- cfg_nblocks  in  NBLK_W  blocks in job; 0 is legal.
- busy  out  1  high from accepted cfg_start until return to S_IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky; cleared by the next accepted cfg_start.
- blocks_done  out  NBLK_W  output blocks accepted by consumer this job.
- in_valid / in_ready / in_data  in / out / in  1/1/128  input block stream.
- out_valid / out_ready / out_data  out / in / out  1/1/128  output block stream.
- core_start  out  1  one-cycle core start pulse.
- core_decrypt  out  1  high for CBC-dec, low otherwise; stable while busy.
- core_in  out  128  core operand; held stable from core_start until core_done.
- core_done  in  1  core completion pulse.
- core_result  in  128  core output; valid when core_done=1.

## Operation
- Latched at accepted cfg_start: mode, nblocks, and chain register (chain <= cfg_iv). blocks_done <= 0, err <= 0.
- States:
  - S_IDLE: cfg_start → S_LOAD. Exception 1: nblocks=0 → done pulse, stay S_IDLE. Exception 2: mode ≥4 → err=1, done pulse, stay S_IDLE.
  - S_LOAD: in_ready=1. On in_valid, register in_data as blk and set core_in per mode; → S_START.
  - S_START: core_start=1 for exactly one cycle; → S_RUN.
  - S_RUN: wait for core_done, then compute out_data and update chain; → S_OUT.
  - S_OUT: out_valid=1. On out_ready: blocks_done += 1. If new count == nblocks: done pulse, → S_IDLE. Otherwise → S_LOAD.
- Mode arithmetic:
  - ECB: core_in = blk; out = core_result.
  - CBC-enc: core_in = blk ^ chain; out = core_result; chain <= core_result.
  - CBC-dec: core_in = blk; out = core_result ^ chain; chain <= blk.
  - CTR: core_in = chain; out = core_result ^ blk; chain <= chain + 1, modulo 2^128, so all-ones wraps to zero.
- Ignored events:
  - core_done outside S_RUN is ignored.
  - cfg_start while busy is ignored; the latched configuration is unchanged.
  - in_valid outside S_LOAD is not accepted.
- Reset, including mid-job, returns the block immediately to S_IDLE. Any in-flight block is discarded; the core is not told.

## Timing
- Reset values:
  - busy, done, err, in_ready, out_valid, core_start, core_decrypt: 0.
  - blocks_done, core_in, out_data: 0.
  - Internal chain register: 0.
- Per-block latency, with out_ready held high: input handshake cycle T, core_start at T+1, core_done at cycle D, out_valid at D+1, next in_ready at D+2.
- out_data and out_valid are registered and held until out_ready. in_ready is asserted only in S_LOAD.
- busy deasserts in the same cycle done pulses.

## Configuration
- `AES_SEQ_TIMEOUT_EN` defined: a watchdog counts cycles in S_RUN. If core_done has not arrived after TIMEOUT_CYCLES cycles, the block sets err=1, pulses done, and returns to S_IDLE. blocks_done keeps its value; out_valid is never raised for that block.
- `AES_SEQ_TIMEOUT_EN` undefined: no watchdog; S_RUN waits indefinitely. err is then set only by an invalid mode.

## Test plan
- ECB, nblocks=2, stub core result = core_in ^ 128'hFF: inputs A, B → outputs A^FF, B^FF; blocks_done=2; one done pulse; core_decrypt=0.
- CBC-enc, iv=128'h1, identity stub core, nblocks=2, inputs 128'h3, 128'h5 → core_in 128'h2, then 128'h7; outputs 128'h2, 128'h7.
- CTR wrap: iv=all-ones, nblocks=2, identity stub, inputs 0, 0 → outputs all-ones, then 0.
- Backpressure plus stray events: hold out_ready=0 for 10 cycles → out_data stable and no second core_start. A core_done and a cfg_start injected in S_OUT are ignored.
- Edge configs:
  - cfg_mode=5 → err=1 and done pulse one cycle after cfg_start, busy never set.
  - nblocks=0 → done pulse, err=0.
  - Assert resetn=0 in S_RUN → all outputs return to reset values asynchronously.
- With `AES_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=8: withhold core_done → err=1 and done pulse 8 cycles after entering S_RUN, blocks_done unchanged.
